// File: rtl/tour_cmd_if.sv
// Handshake/bus bundle between tour_cmd, the tour solver, the UART path and the
// command consumer. slave = tour_cmd side, master = environment side.
interface tour_cmd_if;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        clr_cmd_rdy_UART;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd.sv
// Muxes UART commands or replays a solved knight's tour as Y/X leg commands.
// Optional macro TOUR_FANFARE_EN: final move's X leg uses the fanfare opcode.
module tour_cmd #(
    parameter logic [4:0] LAST_INDX = 5'd23
) (
    input logic       clk,
    input logic       rst_n,
    tour_cmd_if.slave bus
);

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [3:0] OP_MOVE    = 4'b0010;
    localparam logic [3:0] OP_FANFARE = 4'b0011;

    state_t     state_q, state_d;
    logic [4:0] mv_indx_q, mv_indx_d;

    logic [7:0] y_hdg, x_hdg;
    logic [3:0] y_sq, x_sq;
    logic [3:0] x_op;
    logic       last_move;

    assign last_move   = (mv_indx_q == LAST_INDX);
    assign bus.mv_indx = mv_indx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = '0;
                end
            end
            VERT:   if (bus.clr_cmd_rdy) state_d = WAIT_V;
            WAIT_V: if (bus.send_resp)   state_d = HORZ;
            HORZ:   if (bus.clr_cmd_rdy) state_d = WAIT_H;
            WAIT_H: begin
                if (bus.send_resp) begin
                    if (last_move) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Non-one-hot moves fall into default and produce null legs
    always_comb begin
        y_hdg = '0;
        y_sq  = '0;
        x_hdg = '0;
        x_sq  = '0;
        case (bus.move)
            8'h01: begin y_hdg = HDG_N; y_sq = 4'd2; x_hdg = HDG_W; x_sq = 4'd1; end
            8'h02: begin y_hdg = HDG_N; y_sq = 4'd2; x_hdg = HDG_E; x_sq = 4'd1; end
            8'h04: begin y_hdg = HDG_N; y_sq = 4'd1; x_hdg = HDG_W; x_sq = 4'd2; end
            8'h08: begin y_hdg = HDG_S; y_sq = 4'd1; x_hdg = HDG_W; x_sq = 4'd2; end
            8'h10: begin y_hdg = HDG_S; y_sq = 4'd2; x_hdg = HDG_W; x_sq = 4'd1; end
            8'h20: begin y_hdg = HDG_S; y_sq = 4'd2; x_hdg = HDG_E; x_sq = 4'd1; end
            8'h40: begin y_hdg = HDG_S; y_sq = 4'd1; x_hdg = HDG_E; x_sq = 4'd2; end
            8'h80: begin y_hdg = HDG_N; y_sq = 4'd1; x_hdg = HDG_E; x_sq = 4'd2; end
            default: ;
        endcase
    end

`ifdef TOUR_FANFARE_EN
    assign x_op = last_move ? OP_FANFARE : OP_MOVE;
`else
    assign x_op = OP_MOVE;
`endif

    always_comb begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = 8'h5A;
        unique case (state_q)
            IDLE: bus.resp = 8'hA5;
            VERT, WAIT_V: begin
                bus.cmd              = {OP_MOVE, y_hdg, y_sq};
                bus.cmd_rdy          = (state_q == VERT);
                bus.clr_cmd_rdy_UART = 1'b0;
            end
            HORZ, WAIT_H: begin
                bus.cmd              = {x_op, x_hdg, x_sq};
                bus.cmd_rdy          = (state_q == HORZ);
                bus.clr_cmd_rdy_UART = 1'b0;
                if (state_q == WAIT_H && last_move) bus.resp = 8'hA5;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: UART pass-through, leg decode, handshakes,
// mid-tour reset and a full 24-move tour.
module tb_tour_cmd;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;
    int unsigned hs;

    tour_cmd_if bus();

    tour_cmd #(.LAST_INDX(5'd23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TOUR_FANFARE_EN
    localparam logic [15:0] LAST_X = 16'h3BF2;
`else
    localparam logic [15:0] LAST_X = 16'h2BF2;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One leg: command offered, accepted via clr_cmd_rdy, completed via send_resp
    task automatic leg(input logic [15:0] exp_cmd, input logic [7:0] wait_resp);
        check("leg_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("leg_cmd", 32'(bus.cmd), 32'(exp_cmd));
        check("leg_resp", 32'(bus.resp), 32'h5A);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        check("leg_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'd0);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        check("wait_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("wait_cmd", 32'(bus.cmd), 32'(exp_cmd));
        check("wait_resp", 32'(bus.resp), 32'(wait_resp));
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        #1;
        hs++;
    endtask

    task automatic do_move(input logic [7:0] mv, input logic [4:0] idx,
                           input logic [15:0] ey, input logic [15:0] ex,
                           input logic [7:0] last_resp);
        bus.move = mv;
        #1;
        check("mv_indx", 32'(bus.mv_indx), 32'(idx));
        leg(ey, 8'h5A);
        leg(ex, last_resp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs = 0;
        rst_n = 1'b0;
        bus.start_tour   = 1'b0;
        bus.move         = 8'h00;
        bus.cmd_UART     = 16'h2FF1;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b1;
        bus.send_resp    = 1'b0;
        tick();
        tick();
        check("rst_cmd", 32'(bus.cmd), 32'h2FF1);
        check("rst_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("rst_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        check("rst_resp", 32'(bus.resp), 32'hA5);
        check("rst_indx", 32'(bus.mv_indx), 32'd0);
        rst_n = 1'b1;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        tick();

        // Move 0 with ignored-event probes
        bus.move = 8'h01;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        check("v_indx", 32'(bus.mv_indx), 32'd0);
        check("v_cmd", 32'(bus.cmd), 32'h2002);
        check("v_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("v_resp", 32'(bus.resp), 32'h5A);
        tick();
        check("v_hold", 32'(bus.cmd_rdy), 32'd1);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        #1;
        check("v_ign_send_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("v_ign_send_cmd", 32'(bus.cmd), 32'h2002);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        check("wv_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("wv_cmd", 32'(bus.cmd), 32'h2002);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        check("wv_ign_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("wv_ign_cmd", 32'(bus.cmd), 32'h2002);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        #1;
        leg(16'h23F1, 8'h5A);

        do_move(8'h00, 5'd1, 16'h2000, 16'h2000, 8'h5A);
        do_move(8'h03, 5'd2, 16'h2000, 16'h2000, 8'h5A);
        do_move(8'h02, 5'd3, 16'h2002, 16'h2BF1, 8'h5A);
        do_move(8'h04, 5'd4, 16'h2001, 16'h23F2, 8'h5A);
        do_move(8'h40, 5'd5, 16'h27F1, 16'h2BF2, 8'h5A);
        do_move(8'h08, 5'd6, 16'h27F1, 16'h23F2, 8'h5A);
        do_move(8'h10, 5'd7, 16'h27F2, 16'h23F1, 8'h5A);
        do_move(8'h20, 5'd8, 16'h27F2, 16'h2BF1, 8'h5A);
        do_move(8'h80, 5'd9, 16'h2001, 16'h2BF2, 8'h5A);

        // Reset while in WAIT_V of move 10
        bus.move = 8'h01;
        #1;
        check("m10_indx", 32'(bus.mv_indx), 32'd10);
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        check("m10_wait", 32'(bus.cmd_rdy), 32'd0);
        bus.cmd_UART = 16'h1234;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_cmd", 32'(bus.cmd), 32'h1234);
        check("mrst_indx", 32'(bus.mv_indx), 32'd0);
        check("mrst_resp", 32'(bus.resp), 32'hA5);
        check("mrst_rdy", 32'(bus.cmd_rdy), 32'd0);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        tick();
        check("mrst_idle_cmd", 32'(bus.cmd), 32'h1234);
        check("mrst_idle_resp", 32'(bus.resp), 32'hA5);

        // Full tour, start_tour colliding with cmd_rdy_UART
        hs = 0;
        bus.cmd_UART = 16'h2FF1;
        bus.cmd_rdy_UART = 1'b1;
        bus.move = 8'h80;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        check("full_vert_cmd", 32'(bus.cmd), 32'h2001);
        for (int i = 0; i < 24; i++) begin
            do_move(8'h80, 5'(i), 16'h2001, (i == 23) ? LAST_X : 16'h2BF2,
                    (i == 23) ? 8'hA5 : 8'h5A);
        end
        check("full_hs", hs, 32'd48);
        check("end_cmd", 32'(bus.cmd), 32'h2FF1);
        check("end_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("end_resp", 32'(bus.resp), 32'hA5);
        check("end_indx", 32'(bus.mv_indx), 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
